// File: rtl/vector_write_unit.sv
// UART receive path into vector BRAMs A/B: packs byte pairs (low byte first) into
// 16-bit elements and writes them to consecutive addresses of the selected memory.

module vector_write_port (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic en_nxt,
  input  logic we_nxt,
  output logic en,
  output logic we
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en <= 1'b0;
      we <= 1'b0;
    end else begin
      en <= active & en_nxt;
      we <= active & we_nxt;
    end
  end
endmodule

module vector_write_unit #(
  parameter int NUM_ELEMENTOS = 1024,
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              begin_write,
  input  logic              mem_sel,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              ena,
  output logic              enb,
  output logic              wea,
  output logic              web,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              write_done,
  output logic [ADDR_W:0]   elem_count
);
  localparam int NUM_MEMS = 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ELEMENTOS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_LO = 3'd1,
    WAIT_HI = 3'd2,
    COMMIT  = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic en;
    logic we;
    logic commit;
    logic done;
  } ctrl_t;

  state_t            state, state_nxt;
  ctrl_t             ctrl_nxt;
  logic              begin_q;
  logic              sel_q, sel_nxt;
  logic              drain_q;
  logic              start;
  logic [7:0]        lo_byte;
  logic [ADDR_W-1:0] count;
  logic [NUM_MEMS-1:0] en_q, we_q;

  // Only a fresh rising edge starts a transfer, so a level held past DONE is inert.
  assign start   = (state == IDLE) & begin_write & ~begin_q;
  assign sel_nxt = start ? mem_sel : sel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (!begin_write)  state_nxt = IDLE;
        else if (rx_ready) state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (!begin_write)  state_nxt = IDLE;
        else if (rx_ready) state_nxt = COMMIT;
      end
      COMMIT: begin
        if (!begin_write)           state_nxt = IDLE;
        else if (count == LAST_IDX) state_nxt = DRAIN;
        else if (rx_ready)          state_nxt = WAIT_HI;
        else                        state_nxt = WAIT_LO;
      end
      DRAIN:   if (drain_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    ctrl_nxt        = '0;
    ctrl_nxt.en     = state_nxt inside {WAIT_LO, WAIT_HI, COMMIT, DRAIN};
    ctrl_nxt.we     = (state_nxt == COMMIT);
    ctrl_nxt.commit = (state_nxt == COMMIT);
    ctrl_nxt.done   = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      begin_q <= 1'b0;
      sel_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      begin_q <= begin_write;
      sel_q   <= sel_nxt;
      drain_q <= (state == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      lo_byte <= '0;
    end else begin
      if (start)
        count <= '0;
      else if (state == COMMIT && state_nxt inside {WAIT_LO, WAIT_HI})
        count <= count + ADDR_W'(1);
      // A byte arriving during COMMIT is the next element's low byte.
      if ((state == WAIT_LO || state == COMMIT) && state_nxt == WAIT_HI)
        lo_byte <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr      <= '0;
      wdata      <= '0;
      elem_count <= '0;
      write_done <= 1'b0;
    end else begin
      write_done <= ctrl_nxt.done;
      if (start)
        elem_count <= '0;
      else if (ctrl_nxt.commit)
        elem_count <= {1'b0, count} + (ADDR_W+1)'(1);
      if (ctrl_nxt.commit) begin
        waddr <= count;
        wdata <= DATA_W'({rx_data, lo_byte});
      end
    end
  end

  for (genvar m = 0; m < NUM_MEMS; m++) begin : g_port
    vector_write_port u_port (
      .clk    (clk),
      .reset  (reset),
      .active (sel_nxt == 1'(m)),
      .en_nxt (ctrl_nxt.en),
      .we_nxt (ctrl_nxt.we),
      .en     (en_q[m]),
      .we     (we_q[m])
    );
  end

  assign ena = en_q[0];
  assign enb = en_q[1];
  assign wea = we_q[0];
  assign web = we_q[1];

endmodule

// File: tb/tb_vector_write_unit.sv
// Directed bench for vector_write_unit with a 4-element vector.

module tb_vector_write_unit;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          begin_write = 1'b0;
  logic          mem_sel = 1'b0;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          ena, enb, wea, web, write_done;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW:0]   elem_count;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    logic          mem;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  ena_cnt = 0;
  int  enb_cnt = 0;
  int  web_cnt = 0;

  vector_write_unit #(.NUM_ELEMENTOS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .begin_write(begin_write),
    .mem_sel    (mem_sel),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .ena        (ena),
    .enb        (enb),
    .wea        (wea),
    .web        (web),
    .waddr      (waddr),
    .wdata      (wdata),
    .write_done (write_done),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wea || web) wr_q.push_back('{web, waddr, wdata, cyc});
    if (write_done) done_q.push_back(cyc);
    if (ena) ena_cnt <= ena_cnt + 1;
    if (enb) enb_cnt <= enb_cnt + 1;
    if (web) web_cnt <= web_cnt + 1;
  end

  task automatic start_xfer(input logic sel);
    @(negedge clk);
    mem_sel = sel;
    begin_write = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (write_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!got) $display("FAIL %s_done_timeout got=none exp=write_done within 40 cycles", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    begin_write = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({ena, enb, wea, web, write_done} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=00000", {ena, enb, wea, web, write_done});
    else n_pass++;
    n_chk++;
    if (waddr !== '0 || wdata !== '0 || elem_count !== '0)
      $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", waddr, wdata, elem_count);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_vector_a();
    int wb = wr_q.size();
    int db = done_q.size();
    int eb = enb_cnt;
    int wbc = web_cnt;
    logic [7:0] bytes [8];
    bytes = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    start_xfer(1'b0);
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    wait_done("vecA");
    begin_write = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_q.size() - wb != 4) $display("FAIL vecA_nwrites got=%0d exp=4", wr_q.size() - wb);
    else n_pass++;
    if (wr_q.size() - wb >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (wr_q[wb+i].mem !== 1'b0 || wr_q[wb+i].addr !== AW'(i) || wr_q[wb+i].data !== DW'(i + 1))
          $display("FAIL vecA_write%0d got=mem%0d@%0d=%h exp=mem0@%0d=%h", i,
                   wr_q[wb+i].mem, wr_q[wb+i].addr, wr_q[wb+i].data, i, i + 1);
        else n_pass++;
      end
      n_chk++;
      if (done_q.size() - db != 1) $display("FAIL vecA_ndone got=%0d exp=1", done_q.size() - db);
      else if (done_q[db] - wr_q[wb+3].cyc != 3)
        $display("FAIL vecA_done_lat got=%0d exp=3", done_q[db] - wr_q[wb+3].cyc);
      else n_pass++;
    end
    n_chk++;
    if (enb_cnt != eb || web_cnt != wbc)
      $display("FAIL vecA_b_idle got=enb%0d/web%0d exp=0/0", enb_cnt - eb, web_cnt - wbc);
    else n_pass++;
    n_chk++;
    if (elem_count !== 11'd4 || ena !== 1'b0)
      $display("FAIL vecA_idle got=cnt%0d ena%b exp=cnt4 ena0", elem_count, ena);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int wb;
    int ec;
    start_xfer(1'b0);
    send_byte(8'h55);
    n_chk++;
    if (ena !== 1'b1) $display("FAIL arst_pre_ena got=%b exp=1", ena);
    else n_pass++;
    #2;
    reset = 1'b0;
    begin_write = 1'b0;
    #1;
    n_chk++;
    if ({ena, enb, wea, web, write_done} !== 5'b0 || waddr !== '0 || wdata !== '0 || elem_count !== '0)
      $display("FAIL arst_outputs got=%b %h %h %h exp=00000 0 0 0",
               {ena, enb, wea, web, write_done}, waddr, wdata, elem_count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    wb = wr_q.size();
    ec = ena_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    repeat (2) @(negedge clk);
    n_chk++;
    if (wr_q.size() != wb || ena_cnt != ec)
      $display("FAIL arst_no_write got=wr%0d en%0d exp=0/0", wr_q.size() - wb, ena_cnt - ec);
    else n_pass++;
  endtask

  task automatic test_vector_b();
    int wb = wr_q.size();
    int db = done_q.size();
    int ec = ena_cnt;
    int nbad = 0;
    start_xfer(1'b1);
    send_byte(8'h34);
    send_byte(8'h12);
    mem_sel = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i));
    wait_done("vecB");
    begin_write = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_q.size() - wb != 4) $display("FAIL vecB_nwrites got=%0d exp=4", wr_q.size() - wb);
    else n_pass++;
    if (wr_q.size() > wb) begin
      n_chk++;
      if (wr_q[wb].mem !== 1'b1 || wr_q[wb].addr !== '0 || wr_q[wb].data !== 16'h1234)
        $display("FAIL vecB_first got=mem%0d@%0d=%h exp=mem1@0=1234",
                 wr_q[wb].mem, wr_q[wb].addr, wr_q[wb].data);
      else n_pass++;
    end
    for (int i = wb; i < wr_q.size(); i++) if (wr_q[i].mem !== 1'b1) nbad++;
    n_chk++;
    if (nbad != 0 || ena_cnt != ec)
      $display("FAIL vecB_sel_hold got=memA_writes%0d ena%0d exp=0/0", nbad, ena_cnt - ec);
    else n_pass++;
    n_chk++;
    if (done_q.size() - db != 1) $display("FAIL vecB_ndone got=%0d exp=1", done_q.size() - db);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int wb = wr_q.size();
    int db = done_q.size();
    logic [7:0]  bytes [8];
    logic [15:0] exp_d [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_d = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
    start_xfer(1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_ready = 1'b1;
      rx_data = bytes[i];
    end
    @(negedge clk);
    rx_ready = 1'b0;
    wait_done("b2b");
    begin_write = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_q.size() - wb != 4) $display("FAIL b2b_nwrites got=%0d exp=4", wr_q.size() - wb);
    else n_pass++;
    if (wr_q.size() - wb >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (wr_q[wb+i].addr !== AW'(i) || wr_q[wb+i].data !== exp_d[i])
          $display("FAIL b2b_write%0d got=%0d:%h exp=%0d:%h", i,
                   wr_q[wb+i].addr, wr_q[wb+i].data, i, exp_d[i]);
        else n_pass++;
      end
      for (int i = 1; i < 4; i++) begin
        n_chk++;
        if (wr_q[wb+i].cyc - wr_q[wb+i-1].cyc != 2)
          $display("FAIL b2b_spacing%0d got=%0d exp=2", i, wr_q[wb+i].cyc - wr_q[wb+i-1].cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (done_q.size() - db != 1) $display("FAIL b2b_ndone got=%0d exp=1", done_q.size() - db);
    else n_pass++;
  endtask

  task automatic test_abort();
    int wb = wr_q.size();
    int db = done_q.size();
    start_xfer(1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    begin_write = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (wr_q.size() - wb != 1) $display("FAIL abort_nwrites got=%0d exp=1", wr_q.size() - wb);
    else if (wr_q[wb].addr !== '0 || wr_q[wb].data !== 16'hBBAA)
      $display("FAIL abort_write got=%0d:%h exp=0:bbaa", wr_q[wb].addr, wr_q[wb].data);
    else n_pass++;
    n_chk++;
    if (done_q.size() != db || ena !== 1'b0 || elem_count !== 11'd1)
      $display("FAIL abort_idle got=done%0d ena%b cnt%0d exp=0/0/1", done_q.size() - db, ena, elem_count);
    else n_pass++;
    start_xfer(1'b0);
    @(negedge clk);
    n_chk++;
    if (elem_count !== '0 || ena !== 1'b1)
      $display("FAIL abort_restart got=cnt%0d ena%b exp=cnt0 ena1", elem_count, ena);
    else n_pass++;
    send_byte(8'h01);
    send_byte(8'h02);
    begin_write = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (wr_q.size() - wb != 2) $display("FAIL abort_re_nwrites got=%0d exp=2", wr_q.size() - wb);
    else if (wr_q[wb+1].addr !== '0 || wr_q[wb+1].data !== 16'h0201)
      $display("FAIL abort_re_write got=%0d:%h exp=0:0201", wr_q[wb+1].addr, wr_q[wb+1].data);
    else n_pass++;
    n_chk++;
    if (done_q.size() != db) $display("FAIL abort_no_done got=%0d exp=0", done_q.size() - db);
    else n_pass++;
  endtask

  task automatic test_no_retrigger();
    int wb = wr_q.size();
    int db = done_q.size();
    int active = 0;
    start_xfer(1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    wait_done("noretrig");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ena || wea) active++;
    end
    begin_write = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (active != 0) $display("FAIL noretrig_active got=%0d exp=0", active);
    else n_pass++;
    n_chk++;
    if (wr_q.size() - wb != 4 || done_q.size() - db != 1)
      $display("FAIL noretrig_counts got=wr%0d done%0d exp=4/1", wr_q.size() - wb, done_q.size() - db);
    else n_pass++;
    n_chk++;
    if (elem_count !== 11'd4) $display("FAIL noretrig_cnt got=%0d exp=4", elem_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_vector_a();
    test_async_reset();
    test_vector_b();
    test_back_to_back();
    test_abort();
    test_no_retrigger();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/vector_write_unit.md
# vector_write_unit

Receive path between the UART receiver and the two vector BRAMs (A, B). While `controllUnit` is in WRITE and holds `begin_write`, this block packs incoming UART bytes into 16-bit elements (low byte first) and writes them to consecutive addresses of the selected memory. After `NUM_ELEMENTOS` elements it emits `write_done`, which returns `controllUnit` to IDLE.

## Interface
- `NUM_ELEMENTOS`, 1024, elements per vector; must be 2..1024.
- `ADDR_W`, 10, BRAM address width; must satisfy 2^ADDR_W >= NUM_ELEMENTOS.
- `DATA_W`, 16, element width; fixed at two bytes.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `begin_write`  in  1  level from `controllUnit`, high for the whole WRITE state.
- `mem_sel`  in  1  latched command bit 7: 0 = memory A, 1 = memory B.
- `rx_ready`  in  1  one-cycle pulse per received byte.
- `rx_data`  in  8  received byte; valid only when `rx_ready` is high.
- `ena`, `enb`  out  1  BRAM A/B port enables.
- `wea`, `web`  out  1  BRAM A/B write enables.
- `waddr`  out  ADDR_W  write address.
- `wdata`  out  DATA_W  write data, `{hi_byte, lo_byte}`.
- `write_done`  out  1  one-cycle pulse when the vector is complete.
- `elem_count`  out  ADDR_W+1  elements committed so far (debug).

## Operation
- All outputs are registered.
- Reset value of every output and internal register is 0. Reset takes effect immediately, including mid-transfer.
- A transfer starts only on a rising edge of `begin_write` (high now, low on the previous cycle). On that edge the block latches `mem_sel`, clears the count, and moves IDLE→WAIT_LO.
- FSM states: IDLE, WAIT_LO, WAIT_HI, COMMIT, DRAIN, DONE.
  - **WAIT_LO:** on `rx_ready`, store `rx_data` as lo_byte → WAIT_HI.
  - **WAIT_HI:** on `rx_ready`, store hi_byte → COMMIT.
  - **COMMIT** (1 cycle): the selected `we` is high, `waddr` = count, `wdata` = `{hi, lo}`.
    - If count == NUM_ELEMENTOS−1 → DRAIN.
    - Otherwise count++ → WAIT_LO. If `rx_ready` is also high this cycle, that byte is taken as the next lo_byte → WAIT_HI.
  - **DRAIN** (2 cycles): the selected `en` stays high, `we` is low. This gives the BRAM write its settle time.
  - **DONE** (1 cycle): `write_done` = 1, then → IDLE.
- The selected enable (`ena` if `mem_sel`=0, else `enb`) is high from WAIT_LO through DRAIN. The other enable stays 0. Both are 0 in IDLE and DONE.
- The write enable for the unselected memory never rises.
- `elem_count` = count after each commit. It holds its value in IDLE until the next start.
- `rx_ready` is ignored in IDLE, DRAIN and DONE.
- Abort: if `begin_write` falls in WAIT_LO, WAIT_HI or COMMIT, go to IDLE on the next cycle. No `write_done` is issued, enables drop, and the partial data stays in the BRAM.
- `mem_sel` changes after the start edge are ignored.
- A level-high `begin_write` after DONE does not retrigger; a new rising edge is required.

## Timing
- `rx_ready` in WAIT_HI at cycle T: `we` high at T+1 (COMMIT), and WAIT_LO is accepting again at T+2.
- The last hi byte at cycle T gives:
  - `we` at T+1;
  - DRAIN at T+2 and T+3;
  - `write_done` at T+4.
- Interaction with `controllUnit`: it leaves WRITE at T+5, so `begin_write` is low at T+5. This block is already in IDLE by then.
- Minimum byte spacing: 1 cycle. Back-to-back `rx_ready` pulses sustain 1 element per 2 cycles.
- `waddr`/`wdata` hold their last values outside COMMIT.

## Test plan
- **Reset:** `reset`=0 asynchronously mid-WAIT_HI → every output is 0 within the same cycle. After release, `rx_ready` pulses cause no writes.
- **Full vector A** (NUM_ELEMENTOS=4, `mem_sel`=0): bytes 0x01,0x00,0x02,0x00,0x03,0x00,0x04,0x00 → `wea` pulses at addresses 0..3 with data 0x0001..0x0004; `web`/`enb` stay 0; `write_done` is one pulse 3 cycles after the last `wea`; `elem_count`=4.
- **Vector B with byte order:** `mem_sel`=1, bytes 0x34,0x12 → `web` writes 0x1234 at address 0; `ena` stays 0.
- **Back-to-back bytes:** `rx_ready` every cycle for 8 bytes → 4 commits spaced 2 cycles apart, no byte lost, including the byte that arrives during COMMIT.
- **Abort:** `begin_write` falls after 3 bytes → one write at address 0, no `write_done`, state IDLE. A new rising edge restarts at address 0.
- **No retrigger:** `begin_write` held high 10 cycles past `write_done` → no second transfer.
